// File: rtl/mem_access_unit.sv
// MEM stage: word loads/stores over a req/ack data port, pipeline stall
// while a transfer is outstanding, and the MEM/WB pipeline register.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_mem,
  input  logic [4:0]  write_reg_addr_mem,
  input  logic        ctrl_MemToReg_mem,
  input  logic        ctrl_RegWrite_mem,
  input  logic        ctrl_MemRead_mem,
  input  logic        ctrl_MemWrite_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic [31:0] read_data_wb,
  output logic [31:0] alu_result_wb,
  output logic [4:0]  write_reg_addr_wb,
  output logic        ctrl_MemToReg_wb,
  output logic        ctrl_RegWrite_wb,
  output logic        exc_misaligned,
  output logic        exc_timeout
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  wra_q, wra_d;
  logic        m2r_q, m2r_d;
  logic        rw_q, rw_d;
  logic        emis_q, emis_d;
  logic        eto_q, eto_d;
  logic        stall_c;
  logic        mem_op;
  logic        aligned;

  assign mem_op  = ctrl_MemRead_mem | ctrl_MemWrite_mem;
  assign aligned = (alu_result_mem[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    wra_d   = wra_q;
    m2r_d   = m2r_q;
    rw_d    = rw_q;
    emis_d  = 1'b0;
    eto_d   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          alu_d = alu_result_mem;
          wra_d = write_reg_addr_mem;
          m2r_d = ctrl_MemToReg_mem;
          rw_d  = ctrl_RegWrite_mem;
        end else if (!aligned) begin
          alu_d  = alu_result_mem;
          wra_d  = write_reg_addr_mem;
          m2r_d  = 1'b0;
          rw_d   = 1'b0;
          emis_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = ctrl_MemWrite_mem;
          addr_d  = {alu_result_mem[31:2], 2'b00};
          wdata_d = write_data_mem;
          m2r_d   = 1'b0;
          rw_d    = 1'b0;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // ack beats the timeout when both land in the same cycle
        if (dmem_ack) begin
          alu_d   = alu_result_mem;
          wra_d   = write_reg_addr_mem;
          m2r_d   = ctrl_MemToReg_mem;
          rw_d    = ctrl_RegWrite_mem;
          if (!we_q) rd_d = dmem_rdata;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          wra_d   = write_reg_addr_mem;
          m2r_d   = 1'b0;
          rw_d    = 1'b0;
          eto_d   = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          m2r_d   = 1'b0;
          rw_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      wra_q   <= 5'd0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      emis_q  <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      wra_q   <= wra_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      emis_q  <= emis_d;
      eto_q   <= eto_d;
    end
  end

  // held low in reset so the stage never stalls the pipe while reset
  assign stall_mem         = rst_n & stall_c;
  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign read_data_wb      = rd_q;
  assign alu_result_wb     = alu_q;
  assign write_reg_addr_wb = wra_q;
  assign ctrl_MemToReg_wb  = m2r_q;
  assign ctrl_RegWrite_wb  = rw_q;
  assign exc_misaligned    = emis_q;
  assign exc_timeout       = eto_q;

endmodule
